// File: rtl/pixel_writeback.sv
// pixel_writeback
// Sink for the processed-pixel handshake. Each pixel presented with the
// level-valid OKin strobe is packed as {R,G,B} and written once into a
// single-port BRAM at consecutive addresses starting at BASE_ADDR. Every
// accepted pixel is acknowledged, and done is raised once NUM_PIXELS
// pixels of the frame have been written.
//
// Parameters:
//   ADDR_W     - BRAM address width
//   NUM_PIXELS - pixels per frame, 1..2^ADDR_W
//   BASE_ADDR  - first write address of a frame
//
// Ports:
//   clka        in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   arms a frame (honoured in IDLE and DONE only)
//   Rin/Gin/Bin in   8-bit pixel components
//   OKin        in   pixel valid, a level held until ack is seen
//   ack         out  pixel accepted
//   enb/web     out  BRAM enable / write enable (high only while writing)
//   addrb       out  BRAM address
//   dinb        out  BRAM write data {R,G,B}
//   busy        out  frame in progress (ARMED, WRITE, ACK)
//   done        out  frame complete, held until the next start
//   pix_count   out  pixels written in the current frame
module pixel_writeback #(
    parameter int ADDR_W     = 18,
    parameter int NUM_PIXELS = 200000,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        Rin,
    input  logic [7:0]        Gin,
    input  logic [7:0]        Bin,
    input  logic              OKin,
    output logic              ack,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [23:0]       dinb,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pix_count
);

    localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FRAME_LEN = (ADDR_W + 1)'(NUM_PIXELS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_WRITE = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    // Next write address; wraps modulo 2^ADDR_W by construction.
    logic [ADDR_W-1:0] ptr_r;

    // Frame FSM with all outputs registered alongside the state.
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            ack       <= 1'b0;
            enb       <= 1'b0;
            web       <= 1'b0;
            addrb     <= '0;
            dinb      <= 24'h000000;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_ARMED;
                        busy      <= 1'b1;
                        pix_count <= '0;
                        ptr_r     <= BASE_PTR;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end

                ST_ARMED: begin
                    if (OKin) begin
                        // The word is latched here so later input changes
                        // cannot corrupt the write.
                        dinb    <= {Rin, Gin, Bin};
                        addrb   <= ptr_r;
                        enb     <= 1'b1;
                        web     <= 1'b1;
                        state_r <= ST_WRITE;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end

                ST_WRITE: begin
                    enb       <= 1'b0;
                    web       <= 1'b0;
                    ack       <= 1'b1;
                    ptr_r     <= ptr_r + ADDR_W'(1);
                    pix_count <= pix_count + (ADDR_W + 1)'(1);
                    state_r   <= ST_ACK;
                end

                ST_ACK: begin
                    // OKin is a level: while it stays high it is still the
                    // pixel just written, so wait for it to drop.
                    if (!OKin) begin
                        ack <= 1'b0;
                        if (pix_count == FRAME_LEN) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_ARMED;
                        end
                    end else begin
                        state_r <= ST_ACK;
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        pix_count <= '0;
                        ptr_r     <= BASE_PTR;
                        state_r   <= ST_ARMED;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    ack     <= 1'b0;
                    enb     <= 1'b0;
                    web     <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writeback.sv
// Bench for pixel_writeback. Two instances share all inputs: one with a
// wide address bus starting at 0, one with a 3-bit bus starting at 6 so the
// address pointer wraps inside a frame. Written words are captured on the
// BRAM side and compared with a transaction-level model of the frame.
module tb_pixel_writeback;

    localparam int AW_A   = 18;
    localparam int BASE_A = 0;
    localparam int AW_B   = 3;
    localparam int BASE_B = 6;
    localparam int NPIX   = 4;

    logic        clka  = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        OKin  = 1'b0;
    logic [7:0]  Rin   = 8'h00;
    logic [7:0]  Gin   = 8'h00;
    logic [7:0]  Bin   = 8'h00;

    logic            a_ack, a_enb, a_web, a_busy, a_done;
    logic [AW_A-1:0] a_addrb;
    logic [23:0]     a_dinb;
    logic [AW_A:0]   a_pix_count;
    logic            b_ack, b_enb, b_web, b_busy, b_done;
    logic [AW_B-1:0] b_addrb;
    logic [23:0]     b_dinb;
    logic [AW_B:0]   b_pix_count;

    always #5 clka = ~clka;

    pixel_writeback #(.ADDR_W(AW_A), .NUM_PIXELS(NPIX), .BASE_ADDR(BASE_A)) dut_a (
        .clka(clka), .reset(reset), .start(start),
        .Rin(Rin), .Gin(Gin), .Bin(Bin), .OKin(OKin),
        .ack(a_ack), .enb(a_enb), .web(a_web), .addrb(a_addrb), .dinb(a_dinb),
        .busy(a_busy), .done(a_done), .pix_count(a_pix_count)
    );

    pixel_writeback #(.ADDR_W(AW_B), .NUM_PIXELS(NPIX), .BASE_ADDR(BASE_B)) dut_b (
        .clka(clka), .reset(reset), .start(start),
        .Rin(Rin), .Gin(Gin), .Bin(Bin), .OKin(OKin),
        .ack(b_ack), .enb(b_enb), .web(b_web), .addrb(b_addrb), .dinb(b_dinb),
        .busy(b_busy), .done(b_done), .pix_count(b_pix_count)
    );

    int checks = 0;
    int errors = 0;

    // BRAM-side capture: only the monitor writes these queues.
    int wa_addr[$];
    int wa_data[$];
    int wb_addr[$];
    int wb_data[$];

    // Record every word the BRAM would store at this edge.
    always @(posedge clka) begin
        if (a_web) begin
            wa_addr.push_back(int'(a_addrb));
            wa_data.push_back(int'(a_dinb));
        end
        if (b_web) begin
            wb_addr.push_back(int'(b_addrb));
            wb_data.push_back(int'(b_dinb));
        end
    end

    // Model state, owned by the initial block.
    int ea_addr[$];
    int eb_addr[$];
    int e_data[$];
    int rd_a = 0;
    int rd_b = 0;
    int sent = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_a_ack"},  32'(a_ack),  32'd0);
        chk({tag, "_a_web"},  32'(a_web),  32'd0);
        chk({tag, "_a_enb"},  32'(a_enb),  32'd0);
        chk({tag, "_a_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_a_done"}, 32'(a_done), 32'd0);
        chk({tag, "_a_addr"}, 32'(a_addrb), 32'd0);
        chk({tag, "_a_din"},  32'(a_dinb), 32'd0);
        chk({tag, "_a_cnt"},  32'(a_pix_count), 32'd0);
        chk({tag, "_b_web"},  32'(b_web),  32'd0);
        chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
        chk({tag, "_b_cnt"},  32'(b_pix_count), 32'd0);
    endtask

    // Compare captured writes since the last call with the model's list.
    task automatic cmp_writes(input string tag);
        chk({tag, "_a_nwr"}, 32'(wa_addr.size() - rd_a), 32'(ea_addr.size()));
        chk({tag, "_b_nwr"}, 32'(wb_addr.size() - rd_b), 32'(eb_addr.size()));
        for (int i = 0; i < ea_addr.size(); i++) begin
            if (rd_a + i < wa_addr.size()) begin
                chk({tag, "_a_addr"}, 32'(wa_addr[rd_a + i]), 32'(ea_addr[i]));
                chk({tag, "_a_data"}, 32'(wa_data[rd_a + i]), 32'(e_data[i]));
            end
            if (rd_b + i < wb_addr.size()) begin
                chk({tag, "_b_addr"}, 32'(wb_addr[rd_b + i]), 32'(eb_addr[i]));
                chk({tag, "_b_data"}, 32'(wb_data[rd_b + i]), 32'(e_data[i]));
            end
        end
        rd_a = wa_addr.size();
        rd_b = wb_addr.size();
        ea_addr.delete();
        eb_addr.delete();
        e_data.delete();
    endtask

    task automatic start_frame(input string tag);
        @(negedge clka);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        sent  = 0;
        chk({tag, "_busy_a"}, 32'(a_busy), 32'd1);
        chk({tag, "_busy_b"}, 32'(b_busy), 32'd1);
        chk({tag, "_done_a"}, 32'(a_done), 32'd0);
        chk({tag, "_cnt_a"},  32'(a_pix_count), 32'd0);
        chk({tag, "_cnt_b"},  32'(b_pix_count), 32'd0);
    endtask

    // Present one pixel at a falling edge; OKin stays high for 2+hold cycles.
    task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int hold);
        int word;
        int adr_a;
        int adr_b;
        word  = int'({r, g, b});
        adr_a = (BASE_A + sent) % (1 << AW_A);
        adr_b = (BASE_B + sent) % (1 << AW_B);
        ea_addr.push_back(adr_a);
        eb_addr.push_back(adr_b);
        e_data.push_back(word);
        sent++;
        Rin  = r;
        Gin  = g;
        Bin  = b;
        OKin = 1'b1;
        @(negedge clka);
        chk("wr_web_a",  32'(a_web), 32'd1);
        chk("wr_enb_a",  32'(a_enb), 32'd1);
        chk("wr_web_b",  32'(b_web), 32'd1);
        chk("wr_addr_a", 32'(a_addrb), 32'(adr_a));
        chk("wr_addr_b", 32'(b_addrb), 32'(adr_b));
        chk("wr_din_a",  32'(a_dinb), 32'(word));
        Rin = 8'($urandom);
        Gin = 8'($urandom);
        Bin = 8'($urandom);
        @(negedge clka);
        chk("ack_a",     32'(a_ack), 32'd1);
        chk("ack_b",     32'(b_ack), 32'd1);
        chk("ack_web_a", 32'(a_web), 32'd0);
        chk("ack_cnt_a", 32'(a_pix_count), 32'(sent));
        chk("ack_cnt_b", 32'(b_pix_count), 32'(sent));
        chk("hold_din_a", 32'(a_dinb), 32'(word));
        for (int i = 0; i < hold; i++) begin
            @(negedge clka);
            chk("held_ack_a", 32'(a_ack), 32'd1);
            chk("held_web_a", 32'(a_web), 32'd0);
        end
        OKin = 1'b0;
        @(negedge clka);
        chk("post_ack_a",  32'(a_ack), 32'd0);
        chk("post_ack_b",  32'(b_ack), 32'd0);
        chk("post_done_a", 32'(a_done), 32'(sent == NPIX));
        chk("post_done_b", 32'(b_done), 32'(sent == NPIX));
        chk("post_busy_a", 32'(a_busy), 32'(sent != NPIX));
    endtask

    task automatic send_random_frame();
        for (int p = 0; p < NPIX; p++) begin
            send_pix(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        // Reset held, then released into IDLE with OKin toggling.
        reset = 1'b0;
        repeat (3) @(negedge clka);
        chk_quiet("rst_hold");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clka);
            OKin = 1'($urandom_range(0, 1));
            Rin  = 8'($urandom);
        end
        OKin = 1'b0;
        @(negedge clka);
        chk_quiet("rst_idle");
        cmp_writes("rst");

        // Directed frame; the second pixel holds OKin for six cycles.
        start_frame("f1");
        send_pix(8'h10, 8'h20, 8'h30, 0);
        send_pix(8'hFF, 8'h00, 8'h80, 4);
        send_pix(8'h01, 8'h02, 8'h03, 0);
        send_pix(8'hAA, 8'hBB, 8'hCC, 1);
        repeat (2) @(negedge clka);
        chk("f1_done_a", 32'(a_done), 32'd1);
        chk("f1_done_b", 32'(b_done), 32'd1);
        chk("f1_cnt_a",  32'(a_pix_count), 32'(NPIX));
        chk("f1_cnt_b",  32'(b_pix_count), 32'(NPIX));
        cmp_writes("f1");

        // Restart from DONE; start held high during the first pixel is ignored.
        start_frame("f2");
        start = 1'b1;
        send_pix(8'($urandom), 8'($urandom), 8'($urandom), 2);
        start = 1'b0;
        for (int p = 1; p < NPIX; p++) begin
            send_pix(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end
        chk("f2_done_a", 32'(a_done), 32'd1);
        cmp_writes("f2");

        // Reset asserted in the middle of the second pixel's write cycle.
        start_frame("f3");
        send_pix(8'($urandom), 8'($urandom), 8'($urandom), 0);
        Rin  = 8'($urandom);
        OKin = 1'b1;
        @(negedge clka);
        chk("mid_web_a", 32'(a_web), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_web_a",  32'(a_web), 32'd0);
        chk("mid_rst_web_b",  32'(b_web), 32'd0);
        chk("mid_rst_busy_a", 32'(a_busy), 32'd0);
        chk("mid_rst_cnt_a",  32'(a_pix_count), 32'd0);
        @(negedge clka);
        OKin  = 1'b0;
        reset = 1'b1;
        @(negedge clka);
        cmp_writes("f3");

        // Frame after the reset restarts from the base address.
        start_frame("f4");
        send_random_frame();
        chk("f4_done_b", 32'(b_done), 32'd1);
        cmp_writes("f4");

        // Another restart from DONE with a random frame.
        start_frame("f5");
        send_random_frame();
        cmp_writes("f5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_writeback.md
# pixel_writeback

Synthesizable sink for the pixel-processing handshake. It accepts processed RGB pixels presented with a level-valid `OKin` strobe, packs each one into a 24-bit word, and writes the words sequentially into a single-port BRAM. It acknowledges every accepted pixel and signals completion after a programmed frame length. It sits downstream of `process` (its `Rout/Gout/Bout/OKout` drive this block's inputs) and replaces file dumping with an on-chip output frame buffer.

## Interface
- `ADDR_W`, 18, BRAM address width
- `NUM_PIXELS`, 200000, pixels per frame; range 1..2^ADDR_W
- `BASE_ADDR`, 0, first write address
- `clka` in 1: the only clock; all logic on the rising edge
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately
- `start` in 1: arms a frame; sampled in IDLE and DONE only
- `Rin`, `Gin`, `Bin` in 8 each: processed pixel components
- `OKin` in 1: pixel valid, level-sensitive; held by upstream until `ack` is seen
- `ack` out 1: pixel accepted; upstream deasserts `OKin` in response
- `enb`, `web` out 1 each: BRAM enable and write enable
- `addrb` out ADDR_W: BRAM address
- `dinb` out 24: BRAM write data, packed as {R,G,B} with R in [23:16]
- `busy` out 1: high in ARMED, WRITE and ACK
- `done` out 1: frame complete; held high in DONE
- `pix_count` out ADDR_W+1: pixels written in the current frame

## Operation
- The FSM has five states: IDLE, ARMED, WRITE, ACK, DONE. All outputs are registered.
- **IDLE:** `start`=1 → ARMED. `pix_count`←0 and the address pointer ←`BASE_ADDR`. `OKin` is ignored.
- **ARMED:** `OKin`=1 → capture `{Rin,Gin,Bin}` into `dinb` and go to WRITE. Otherwise stay.
- **WRITE:** lasts exactly one cycle with `enb`=`web`=1, `addrb`=pointer and `dinb`=captured word. On exit, the pointer increments, `pix_count` increments, and the FSM goes to ACK.
- **ACK:** `ack`=1. Stay while `OKin`=1. On the first cycle `OKin`=0, go to DONE if `pix_count`==`NUM_PIXELS`, otherwise to ARMED.
- The ACK state exists because `OKin` is a level. Exactly one write occurs per `OKin` high period, however long that period lasts.
- **DONE:** `done`=1 and `enb`=`web`=0. `start`=1 → ARMED with the counters re-initialised, as in IDLE. `done` clears on that transition.
- `start` is ignored while `busy`=1.
- Input changes on `Rin/Gin/Bin` after capture do not affect `dinb`.
- The pointer is computed modulo 2^ADDR_W. If `BASE_ADDR+NUM_PIXELS` exceeds 2^ADDR_W, the pointer wraps to 0. This wrap is defined behaviour, not an error.
- `enb` is high only in WRITE. This block never reads the BRAM.

## Timing
- Reset values: state IDLE; `ack`, `enb`, `web`, `busy`, `done` = 0; `addrb`, `dinb`, `pix_count` = 0.
- Reset mid-frame: `web` falls asynchronously, so a write in progress may be lost. No partial-word write is ever issued.
- Edge k, with ARMED and `OKin` sampled 1: `web`=1 in cycle k→k+1.
- Edge k+1: `ack`=1 and `pix_count` is updated.
- Minimum period per pixel: 3 cycles. This requires `OKin` to drop in the first ACK cycle and rise again in the next ARMED cycle.
- Last pixel: `done` rises at the edge where ACK sees `OKin`=0. `busy` falls at the same edge.
- `OKin`=1 seen in ACK is treated as the same pixel, never as a new one.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release with `start`=0 → all outputs 0 and no `web` pulse over 20 cycles, even with `OKin` toggling.
- **Frame:** with `NUM_PIXELS`=4 and `BASE_ADDR`=0, send pixels (10,20,30), (FF,00,80), (01,02,03), (AA,BB,CC) → exactly four `web` pulses at addrb 0..3 with dinb 0x102030, 0xFF0080, 0x010203, 0xAABBCC. `done`=1 after the fourth ACK, and `pix_count`=4.
- **Held valid:** hold `OKin`=1 for 6 cycles → one write only. `ack` stays high until `OKin` falls, then the FSM returns to ARMED.
- **Wrap:** with `ADDR_W`=3, `BASE_ADDR`=6 and `NUM_PIXELS`=4 → write addresses 6, 7, 0, 1.
- **Reset mid-frame:** assert `reset` during WRITE of pixel 2 → `web` drops immediately. After release, `start` causes the frame to restart at `BASE_ADDR` with `pix_count`=0.
- **Restart from DONE:** pulse `start` in DONE → `done` falls the next cycle, `busy` rises, and the next frame writes from `BASE_ADDR` again.
